victim_select: RTL and testbench
================================

# victim_select

Random-replacement victim selector for the set-associative cache controller. It sits directly downstream of the cache's Fibonacci LFSR and turns each miss request into one stable victim-way index. It prefers invalid ways, skips locked ways, and uses the LFSR value only when every unlocked way is valid. After each accepted victim it pulses the LFSR enable, so the next miss sees a fresh random value.

## Interface
- WAYS, 4, number of ways in a set; must be a power of two, 2..16
- WAY_BITS, 2, log2(WAYS); width of the way index
- RAND_BITS, 5, width of the LFSR value; must be ≥ WAY_BITS
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  1  miss needs a victim; sampled only in IDLE
- valid_bits  input  WAYS  per-way valid flags of the addressed set
- lock_bits  input  WAYS  per-way lock flags; a locked way is never chosen
- rand_in  input  RAND_BITS  current LFSR output
- victim_ack  input  1  controller has consumed the victim; sampled only in HOLD
- victim_valid  output  1  victim_way is valid and stable
- victim_way  output  WAY_BITS  chosen way index
- no_victim  output  1  one-cycle pulse: every way of the set is locked
- lfsr_enable  output  1  one-cycle pulse that advances the upstream LFSR

## Operation
- Reset (rst low, asynchronous) forces:
  - state IDLE;
  - victim_valid = 0, victim_way = 0, no_victim = 0, lfsr_enable = 0;
  - snapshot registers = 0.
- The FSM has four states: IDLE, SCAN, RAND, HOLD.
- IDLE:
  - If req = 1, register snapshots: vmask <= valid_bits, lmask <= lock_bits, cand <= rand_in[WAY_BITS-1:0]. Go to SCAN.
  - Otherwise stay in IDLE.
- SCAN, evaluated on the snapshots only (live inputs are ignored):
  - If any way has lmask = 0 and vmask = 0: victim_way <= lowest such index; go to HOLD.
  - Else if lmask is all ones: pulse no_victim; go to IDLE.
  - Else go to RAND.
- RAND:
  - If lmask[cand] = 0: victim_way <= cand; go to HOLD.
  - Else cand <= cand + 1, wrapping modulo WAYS; stay in RAND.
  - Termination is guaranteed because at least one way is unlocked; at most WAYS-1 extra cycles.
- HOLD:
  - victim_valid = 1; victim_way is held constant.
  - On victim_ack = 1: victim_valid <= 0, lfsr_enable <= 1 for exactly one cycle; go to IDLE.
- Ignore rules:
  - req outside IDLE is ignored; it is not queued.
  - victim_ack outside HOLD is ignored.
- lfsr_enable never asserts on the no_victim path; the LFSR advances only on consumed victims.
- All outputs are registered; there is no combinational path from any input to any output.

## Timing
- Cycle numbering: req sampled at edge 0.
- Invalid-way path: victim_valid = 1 after edge 2.
- Random path, first candidate unlocked: victim_valid = 1 after edge 3.
- Random path, each locked candidate skipped adds 1 cycle.
- All ways locked: no_victim = 1 for the cycle after edge 2 only; state is IDLE after edge 2.
- Ack handshake: victim_ack sampled high at edge k gives, after edge k:
  - victim_valid = 0;
  - lfsr_enable = 1 for exactly one cycle.
- Back-to-back: a new req is accepted one cycle after the ack edge, i.e. at edge k+1, while lfsr_enable is high. It therefore snapshots the pre-advance rand_in. This is accepted behaviour.
- Reset mid-operation (any state): outputs return to reset values immediately. No lfsr_enable or no_victim pulse is generated.

## Test plan
- Invalid preference: WAYS=4, valid_bits=4'b1011, lock_bits=0, rand_in=5'h1f, req at edge 0.
  - Expect victim_way=2, victim_valid high after edge 2.
  - Ack at edge 4 → lfsr_enable high for one cycle after edge 4.
- Random pick: valid_bits=4'hf, lock_bits=0, rand_in=5'b10110.
  - Expect victim_way=2 after edge 3.
  - victim_way stays stable through 5 cycles of ack=0.
- Locked skip with wrap: valid_bits=4'hf, lock_bits=4'b1001, rand_in=5'b00011.
  - Candidate 3 is locked, wraps to 0 (locked), then 1.
  - Expect victim_way=1, victim_valid after edge 5.
- All locked: lock_bits=4'hf.
  - Expect no_victim pulse for one cycle after edge 2.
  - victim_valid and lfsr_enable stay 0.
  - A fresh req is accepted at edge 3.
- Reset and ignore rules:
  - Assert rst low while in RAND with lock_bits=4'b1110 → all outputs 0 immediately; IDLE after release.
  - req held high during HOLD does not change victim_way.
  - Spurious victim_ack in IDLE produces no lfsr_enable.

Source files
------------

// File: rtl/victim_select.sv
// Random-replacement victim selector: prefers invalid ways, skips locked ways,
// falls back to the LFSR value, and advances the LFSR once per consumed victim.
module victim_select #(
    parameter int unsigned WAYS      = 4,
    parameter int unsigned WAY_BITS  = 2,
    parameter int unsigned RAND_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [WAYS-1:0]      valid_bits,
    input  logic [WAYS-1:0]      lock_bits,
    input  logic [RAND_BITS-1:0] rand_in,
    input  logic                 victim_ack,
    output logic                 victim_valid,
    output logic [WAY_BITS-1:0]  victim_way,
    output logic                 no_victim,
    output logic                 lfsr_enable
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RAND,
        HOLD
    } state_t;

    state_t state, state_n;

    logic [WAYS-1:0]     vmask, vmask_n;
    logic [WAYS-1:0]     lmask, lmask_n;
    logic [WAY_BITS-1:0] cand, cand_n;

    // SCAN is split in two cycles: the first registers the priority-encode
    // result, the second acts on it, keeping the wide encoder off the FSM path.
    logic                scan_stage, scan_stage_n;
    logic                free_found, free_found_n;
    logic [WAY_BITS-1:0] free_idx, free_idx_n;
    logic                all_locked, all_locked_n;

    logic                victim_valid_n;
    logic [WAY_BITS-1:0] victim_way_n;
    logic                no_victim_n;
    logic                lfsr_enable_n;

    logic                enc_found;
    logic [WAY_BITS-1:0] enc_idx;

    logic unused_rand;
    assign unused_rand = ^rand_in;

    // Lowest unlocked invalid way; scanning downward lets the lowest index win.
    always_comb begin
        enc_found = 1'b0;
        enc_idx   = '0;
        for (int unsigned i = WAYS; i > 0; i--) begin
            if (!lmask[i-1] && !vmask[i-1]) begin
                enc_found = 1'b1;
                enc_idx   = WAY_BITS'(i - 1);
            end
        end
    end

    always_comb begin
        state_n        = state;
        vmask_n        = vmask;
        lmask_n        = lmask;
        cand_n         = cand;
        scan_stage_n   = scan_stage;
        free_found_n   = free_found;
        free_idx_n     = free_idx;
        all_locked_n   = all_locked;
        victim_valid_n = victim_valid;
        victim_way_n   = victim_way;
        no_victim_n    = 1'b0;
        lfsr_enable_n  = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    vmask_n      = valid_bits;
                    lmask_n      = lock_bits;
                    cand_n       = rand_in[WAY_BITS-1:0];
                    scan_stage_n = 1'b0;
                    state_n      = SCAN;
                end
            end
            SCAN: begin
                if (!scan_stage) begin
                    free_found_n = enc_found;
                    free_idx_n   = enc_idx;
                    all_locked_n = &lmask;
                    scan_stage_n = 1'b1;
                end else begin
                    scan_stage_n = 1'b0;
                    if (free_found) begin
                        victim_way_n   = free_idx;
                        victim_valid_n = 1'b1;
                        state_n        = HOLD;
                    end else if (all_locked) begin
                        no_victim_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        state_n = RAND;
                    end
                end
            end
            RAND: begin
                if (!lmask[cand]) begin
                    victim_way_n   = cand;
                    victim_valid_n = 1'b1;
                    state_n        = HOLD;
                end else begin
                    // WAYS is a power of two, so natural overflow wraps the index.
                    cand_n = cand + 1'b1;
                end
            end
            HOLD: begin
                if (victim_ack) begin
                    victim_valid_n = 1'b0;
                    lfsr_enable_n  = 1'b1;
                    state_n        = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vmask        <= '0;
            lmask        <= '0;
            cand         <= '0;
            scan_stage   <= 1'b0;
            free_found   <= 1'b0;
            free_idx     <= '0;
            all_locked   <= 1'b0;
            victim_valid <= 1'b0;
            victim_way   <= '0;
            no_victim    <= 1'b0;
            lfsr_enable  <= 1'b0;
        end else begin
            vmask        <= vmask_n;
            lmask        <= lmask_n;
            cand         <= cand_n;
            scan_stage   <= scan_stage_n;
            free_found   <= free_found_n;
            free_idx     <= free_idx_n;
            all_locked   <= all_locked_n;
            victim_valid <= victim_valid_n;
            victim_way   <= victim_way_n;
            no_victim    <= no_victim_n;
            lfsr_enable  <= lfsr_enable_n;
        end
    end

endmodule

// File: tb/tb_victim_select.sv
// Directed bench for victim_select: timing of each selection path, handshake,
// reset and ignore rules, with hand-computed expectations.
module tb_victim_select;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [3:0] valid_bits;
    logic [3:0] lock_bits;
    logic [4:0] rand_in;
    logic       victim_ack;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic       no_victim;
    logic       lfsr_enable;

    int vecs = 0;
    int errs = 0;

    victim_select #(
        .WAYS      (4),
        .WAY_BITS  (2),
        .RAND_BITS (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .valid_bits   (valid_bits),
        .lock_bits    (lock_bits),
        .rand_in      (rand_in),
        .victim_ack   (victim_ack),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .no_victim    (no_victim),
        .lfsr_enable  (lfsr_enable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic vv, input logic [1:0] vw,
                              input logic nv, input logic le);
        check({tag, ".victim_valid"}, {7'd0, victim_valid}, {7'd0, vv});
        check({tag, ".victim_way"},   {6'd0, victim_way},   {6'd0, vw});
        check({tag, ".no_victim"},    {7'd0, no_victim},    {7'd0, nv});
        check({tag, ".lfsr_enable"},  {7'd0, lfsr_enable},  {7'd0, le});
    endtask

    initial begin
        rst        = 1'b0;
        req        = 1'b0;
        valid_bits = '0;
        lock_bits  = '0;
        rand_in    = '0;
        victim_ack = 1'b0;

        // Reset state
        tick();
        check_outs("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // Invalid preference: way 2 is the only invalid way
        valid_bits = 4'b1011; lock_bits = 4'b0000; rand_in = 5'h1f; req = 1'b1;
        tick();                                    // edge 0
        req = 1'b0;
        check_outs("inv.e0", 1'b0, 2'd0, 1'b0, 1'b0);
        tick();                                    // edge 1
        check_outs("inv.e1", 1'b0, 2'd0, 1'b0, 1'b0);
        tick();                                    // edge 2
        check_outs("inv.e2", 1'b1, 2'd2, 1'b0, 1'b0);
        tick();                                    // edge 3
        check_outs("inv.e3", 1'b1, 2'd2, 1'b0, 1'b0);
        victim_ack = 1'b1;
        tick();                                    // edge 4
        victim_ack = 1'b0;
        check_outs("inv.ack", 1'b0, 2'd2, 1'b0, 1'b1);
        tick();
        check_outs("inv.ack+1", 1'b0, 2'd2, 1'b0, 1'b0);

        // Random pick: all valid, rand low bits = 2; req held through HOLD
        valid_bits = 4'hf; lock_bits = 4'h0; rand_in = 5'b10110; req = 1'b1;
        tick();                                    // edge 0
        req = 1'b0;
        tick();                                    // edge 1
        tick();                                    // edge 2
        check_outs("rnd.e2", 1'b0, 2'd2, 1'b0, 1'b0);
        tick();                                    // edge 3
        check_outs("rnd.e3", 1'b1, 2'd2, 1'b0, 1'b0);
        req = 1'b1; valid_bits = 4'h0; rand_in = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs("rnd.hold", 1'b1, 2'd2, 1'b0, 1'b0);
        end
        req = 1'b0; victim_ack = 1'b1;
        tick();
        victim_ack = 1'b0;
        check_outs("rnd.ack", 1'b0, 2'd2, 1'b0, 1'b1);

        // Locked skip with wrap: cand 3 locked, 0 locked, 1 chosen
        valid_bits = 4'hf; lock_bits = 4'b1001; rand_in = 5'b00011; req = 1'b1;
        tick();                                    // edge 0
        req = 1'b0;
        check_outs("lck.e0", 1'b0, 2'd2, 1'b0, 1'b0);
        tick();                                    // edge 1
        tick();                                    // edge 2
        tick();                                    // edge 3
        tick();                                    // edge 4
        check_outs("lck.e4", 1'b0, 2'd2, 1'b0, 1'b0);
        tick();                                    // edge 5
        check_outs("lck.e5", 1'b1, 2'd1, 1'b0, 1'b0);
        victim_ack = 1'b1;
        tick();
        victim_ack = 1'b0;
        check_outs("lck.ack", 1'b0, 2'd1, 1'b0, 1'b1);

        // All locked: no_victim pulse, then a fresh req accepted at edge 3
        valid_bits = 4'h0; lock_bits = 4'hf; rand_in = 5'b00010; req = 1'b1;
        tick();                                    // edge 0
        req = 1'b0;
        tick();                                    // edge 1
        check_outs("all.e1", 1'b0, 2'd1, 1'b0, 1'b0);
        tick();                                    // edge 2
        check_outs("all.e2", 1'b0, 2'd1, 1'b1, 1'b0);
        valid_bits = 4'b0111; lock_bits = 4'h0; req = 1'b1;
        tick();                                    // edge 3, fresh req
        req = 1'b0;
        check_outs("all.e3", 1'b0, 2'd1, 1'b0, 1'b0);
        tick();                                    // edge 4
        check_outs("all.e4", 1'b0, 2'd1, 1'b0, 1'b0);
        tick();                                    // edge 5
        check_outs("all.e5", 1'b1, 2'd3, 1'b0, 1'b0);
        victim_ack = 1'b1;
        tick();
        victim_ack = 1'b0;
        check_outs("all.ack", 1'b0, 2'd3, 1'b0, 1'b1);
        tick();

        // Reset while in RAND: cand 1 locked, walking toward way 0
        valid_bits = 4'hf; lock_bits = 4'b1110; rand_in = 5'b00001; req = 1'b1;
        tick();                                    // edge 0
        req = 1'b0;
        tick();                                    // edge 1
        tick();                                    // edge 2, now in RAND
        tick();                                    // edge 3, still in RAND
        check_outs("rst.pre", 1'b0, 2'd3, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_outs("rst.async", 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check_outs("rst.post", 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        check_outs("rst.post2", 1'b0, 2'd0, 1'b0, 1'b0);
        valid_bits = 4'b1101; lock_bits = 4'h0; req = 1'b1;
        tick();                                    // edge 0
        req = 1'b0;
        tick();                                    // edge 1
        tick();                                    // edge 2
        check_outs("rst.idle", 1'b1, 2'd1, 1'b0, 1'b0);
        victim_ack = 1'b1;
        tick();
        victim_ack = 1'b0;
        check_outs("rst.ack", 1'b0, 2'd1, 1'b0, 1'b1);
        tick();

        // Spurious ack in IDLE
        victim_ack = 1'b1;
        tick();
        check_outs("spur.ack", 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        victim_ack = 1'b0;
        check_outs("spur.ack2", 1'b0, 2'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
